// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the BTB: counter encodings, saturating arithmetic
// and PC index/tag slicing.
package branch_predictor_pkg;

  localparam int unsigned PC_MAX_W  = 64;
  localparam int unsigned CTR_MAX_W = 8;

  typedef logic [CTR_MAX_W-1:0] ctr_wide_t;
  typedef logic [PC_MAX_W-1:0]  pc_wide_t;

  typedef enum logic [1:0] {
    CTR_INC,
    CTR_DEC,
    CTR_SET_STRONG,
    CTR_SET_WEAK_T
  } ctr_op_t;

  // Counter encodings for a counter of the given width.
  function automatic ctr_wide_t ctr_strong_t(input int unsigned bits);
    return (ctr_wide_t'(1) << bits) - ctr_wide_t'(1);
  endfunction

  function automatic ctr_wide_t ctr_weak_t(input int unsigned bits);
    return ctr_wide_t'(1) << (bits - 1);
  endfunction

  function automatic ctr_wide_t ctr_weak_nt(input int unsigned bits);
    return ctr_strong_t(bits) >> 1;
  endfunction

  function automatic ctr_wide_t ctr_strong_nt();
    return '0;
  endfunction

  function automatic ctr_wide_t ctr_sat_inc(input ctr_wide_t c, input int unsigned bits);
    return (c == ctr_strong_t(bits)) ? c : c + ctr_wide_t'(1);
  endfunction

  function automatic ctr_wide_t ctr_sat_dec(input ctr_wide_t c);
    return (c == ctr_strong_nt()) ? c : c - ctr_wide_t'(1);
  endfunction

  // Word-aligned PC split: index above the byte offset, tag above the index.
  function automatic pc_wide_t pc_index(input pc_wide_t pc, input int unsigned idx_bits);
    return (pc >> 2) & ((pc_wide_t'(1) << idx_bits) - pc_wide_t'(1));
  endfunction

  function automatic pc_wide_t pc_tag(input pc_wide_t pc, input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_array.sv
// Array of saturating direction counters: one combinational read port returning
// the taken bit, one synchronous update port.
module branch_predictor_sat_counter_array
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned IDX      = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IDX-1:0] rd_idx,
  output logic           rd_taken,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  ctr_op_t        wr_op
);

  logic [CTR_BITS-1:0] ctrs [ENTRIES];
  ctr_wide_t           cur_ctr;
  ctr_wide_t           next_ctr;

  assign rd_taken = ctrs[rd_idx][CTR_BITS-1];
  assign cur_ctr  = CTR_MAX_W'(ctrs[wr_idx]);

  always_comb begin
    next_ctr = cur_ctr;
    case (wr_op)
      CTR_INC:        next_ctr = ctr_sat_inc(cur_ctr, CTR_BITS);
      CTR_DEC:        next_ctr = ctr_sat_dec(cur_ctr);
      CTR_SET_STRONG: next_ctr = ctr_strong_t(CTR_BITS);
      CTR_SET_WEAK_T: next_ctr = ctr_weak_t(CTR_BITS);
      default:        next_ctr = cur_ctr;
    endcase
  end

  // Counters come out of reset weakly not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctrs[i] <= CTR_BITS'(ctr_weak_nt(CTR_BITS));
    end else if (wr_en) begin
      ctrs[wr_idx] <= CTR_BITS'(next_ctr);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: same-cycle prediction for
// Fetch, update and mispredict detection from Memory.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcF,
  output logic            predtakenF,
  output logic [XLEN-1:0] predtargetF,
  input  logic            invalidate,
  input  logic            updateM,
  input  logic [XLEN-1:0] pcM,
  input  logic            takenM,
  input  logic            uncondM,
  input  logic [XLEN-1:0] targetM,
  input  logic            predtakenM,
  input  logic [XLEN-1:0] predtargetM,
  output logic            mispredictM,
  output logic [XLEN-1:0] redirectpcM,
  output logic [31:0]     mispredcount
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [XLEN-1:0]    targets [ENTRIES];

  logic [IDX-1:0]   idx_f, idx_m;
  logic [TAG_W-1:0] tag_f, tag_m;
  logic             hit_f, hit_m, ctr_taken_f, ctr_we;
  ctr_op_t          ctr_op;

  assign idx_f = IDX'(pc_index(PC_MAX_W'(pcF), IDX));
  assign tag_f = TAG_W'(pc_tag(PC_MAX_W'(pcF), IDX));
  assign idx_m = IDX'(pc_index(PC_MAX_W'(pcM), IDX));
  assign tag_m = TAG_W'(pc_tag(PC_MAX_W'(pcM), IDX));

  assign hit_f = valid[idx_f] & (tags[idx_f] == tag_f);
  assign hit_m = valid[idx_m] & (tags[idx_m] == tag_m);

  assign predtakenF  = hit_f & ctr_taken_f;
  assign predtargetF = predtakenF ? targets[idx_f] : pcF + XLEN'(4);

  assign mispredictM = updateM & ((predtakenM != takenM) | (takenM & (predtargetM != targetM)));
  assign redirectpcM = takenM ? targetM : pcM + XLEN'(4);

  // Hits train the counter; taken misses allocate; invalidate drops the update.
  always_comb begin
    ctr_we = updateM & ~invalidate & (hit_m | takenM);
    ctr_op = CTR_INC;
    if (uncondM)      ctr_op = CTR_SET_STRONG;
    else if (!hit_m)  ctr_op = CTR_SET_WEAK_T;
    else if (!takenM) ctr_op = CTR_DEC;
  end

  branch_predictor_sat_counter_array #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .IDX      (IDX)
  ) u_sat_counter_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx_f),
    .rd_taken (ctr_taken_f),
    .wr_en    (ctr_we),
    .wr_idx   (idx_m),
    .wr_op    (ctr_op)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
      end
    end else if (invalidate) begin
      valid <= '0;
    end else if (updateM && takenM) begin
      if (!hit_m) begin
        valid[idx_m] <= 1'b1;
        tags[idx_m]  <= tag_m;
      end
      targets[idx_m] <= targetM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredcount <= '0;
    end else if (mispredictM && (mispredcount != 32'hFFFF_FFFF)) begin
      mispredcount <= mispredcount + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with per-entry saturating counters.
- Supplies a predicted next-PC to Fetch in the same cycle as the PC lookup.
- Takes the resolved branch outcome back from Memory, updates its tables, and flags mispredicts with the corrected PC.
- Replaces the current always-not-taken policy, where every taken branch or jump costs a flush.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB depth; power of two, >= 2. IDX = log2(ENTRIES).
- CTR_BITS, 2, saturating counter width; >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pcF  in  XLEN  fetch PC to look up.
- predtakenF  out  1  prediction: taken.
- predtargetF  out  XLEN  predicted target; equals pcF+4 when predtakenF=0.
- invalidate  in  1  synchronous clear of all valid bits (fence.i).
- updateM  in  1  resolved control-transfer instruction in M.
- pcM  in  XLEN  PC of the resolved instruction.
- takenM  in  1  actual outcome.
- uncondM  in  1  unconditional jump (jal/jalr).
- targetM  in  XLEN  actual target.
- predtakenM  in  1  prediction carried down the pipe.
- predtargetM  in  XLEN  predicted target carried down the pipe.
- mispredictM  out  1  redirect required.
- redirectpcM  out  XLEN  correct next PC.
- mispredcount  out  32  count of mispredicts.

Behaviour:
- Address split:
  - index = pc[IDX+1:2]
  - tag = pc[XLEN-1:IDX+2]
  - pc[1:0] is ignored.
- Per-entry storage: valid, tag, target (XLEN), counter (CTR_BITS).
- Lookup is purely combinational:
  - hit = valid[index] & (tag match).
  - predtakenF = hit & counter MSB.
  - predtargetF = predtakenF ? stored target : pcF+4.
- Mispredict logic is combinational, gated by updateM:
  - mispredictM = updateM & ((predtakenM != takenM) | (takenM & predtargetM != targetM)).
  - redirectpcM = takenM ? targetM : pcM+4, valid whenever updateM=1.
- Update on a rising edge when updateM=1 and invalidate=0:
  - Hit, takenM=1: counter saturating increment; target <= targetM.
  - Hit, takenM=0: counter saturating decrement; target unchanged.
  - Hit, uncondM=1: counter <= all ones.
  - Miss, takenM=1: allocate/replace the entry. valid=1, tag and target written. Counter = all ones if uncondM, else weakly taken (MSB=1, other bits 0).
  - Miss, takenM=0: no change.
- Lookup/update collision on the same index in the same cycle: lookup returns pre-update contents; the write takes effect at the edge.
- Counter saturation: never wraps past 0 or 2^CTR_BITS-1.
- mispredcount:
  - Increments on each edge with mispredictM=1.
  - Saturates at 32'hFFFFFFFF.
  - Unaffected by invalidate.
- invalidate:
  - Clears all valid bits at the edge and takes priority over a same-cycle update (that update is dropped).
  - Counters and targets are left as they are.
  - mispredictM is still computed normally in that cycle.
- Reset, asserted at any time including mid-update:
  - All valid bits and mispredcount clear immediately.
  - Counters reset to weakly not-taken (MSB=0, other bits 1); targets reset to 0.
  - Outputs under reset: predtakenF=0, predtargetF=pcF+4, mispredcount=0.
- Stalls are the integrator's concern. The block holds no pipeline state; the integrator must carry predtakenF/predtargetF through the F/D/E/M pipe registers alongside the PC.

Decomposition:
- Shared package:
  - the counter encodings (strongly/weakly taken and not-taken) as constants derived from CTR_BITS;
  - the saturating increment/decrement function;
  - the index/tag slicing function parameterised by IDX.
- One natural sub-module: sat_counter_array, holding ENTRIES counters with one read port and one update port.
- Tag, target and valid arrays stay in the top module.

Test Plan:
- Reset, then lookup pcF=0x100 -> predtakenF=0, predtargetF=0x104, mispredcount=0.
- Update pcM=0x100, takenM=1, targetM=0x200, predtakenM=0 -> mispredictM=1, redirectpcM=0x200. Next cycle, pcF=0x100 -> predtakenF=1, predtargetF=0x200; mispredcount=1.
- Same entry, two not-taken updates -> counter 10 to 01 to 00; lookup 0x100 gives predtakenF=0. Three more taken updates -> 11, saturating; a fourth taken update leaves it at 11.
- Aliasing with ENTRIES=16: allocate 0x100 taken, then allocate 0x140 taken (same index 0, different tag) -> lookup 0x100 misses, lookup 0x140 hits with the new target.
- Collision: in the cycle an allocation for 0x100 is written, pcF=0x100 -> predtakenF=0 that cycle, 1 the next. invalidate together with an update -> all lookups miss afterwards.
- Assert reset low mid-update with valid entries and mispredcount=5 -> outputs clear immediately, without waiting for a clock edge. After release, all lookups miss.
